// File: rtl/ofm_buffer.sv
// ofm_buffer: multi-channel output-feature-map buffer behind the conv PE array.
// It keeps the stride-grid positions of a raster stream of stride-1 window results
// and accumulates them across input-channel passes. It then drains the finished
// OFM as a valid/ready raster stream.
// Optional build macro OFM_BUFFER_SAT_ACC_EN: when defined, accumulation saturates
// to the signed range of each channel. When it is undefined, accumulation wraps.
module ofm_buffer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned IFM_SIZE    = 9,
    parameter int unsigned KERNEL_SIZE = 4,
    parameter int unsigned STRIDE      = 2,
    parameter int unsigned PAD         = 2,
    parameter int unsigned NUM_CHANNEL = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [NUM_CHANNEL*DATA_WIDTH-1:0] d_in,
    input  logic                              last_pass,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [NUM_CHANNEL*DATA_WIDTH-1:0] d_out,
    output logic                              rd_last,
    output logic                              frame_done
);

    localparam int unsigned CONV_SIZE = IFM_SIZE - KERNEL_SIZE + 2*PAD + 1;
    localparam int unsigned OFM_SIZE  = (IFM_SIZE - KERNEL_SIZE + 2*PAD) / STRIDE + 1;
    localparam int unsigned DEPTH     = OFM_SIZE * OFM_SIZE;
    localparam int unsigned WORD_W    = NUM_CHANNEL * DATA_WIDTH;
    localparam int unsigned CNT_W     = $clog2(CONV_SIZE + 1);
    localparam int unsigned ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PTR_W     = $clog2(DEPTH + 1);

`ifdef OFM_BUFFER_SAT_ACC_EN
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic {WRITE, READ} state_t;

    state_t               state;
    logic [CNT_W-1:0]     x_cnt;
    logic [CNT_W-1:0]     y_cnt;
    logic                 first_pass;
    logic [PTR_W-1:0]     rd_ptr;
    logic [WORD_W-1:0]    mem [DEPTH];

    logic                 wr_fire_c;
    logic                 store_c;
    logic                 row_end_c;
    logic                 end_pass_c;
    logic                 rd_load_c;
    logic                 rd_done_c;
    logic [ADDR_W-1:0]    wr_addr_c;
    logic [WORD_W-1:0]    mem_rd_c;
    logic [WORD_W-1:0]    wr_data_c;
    logic [DATA_WIDTH-1:0] lane_old;
    logic [DATA_WIDTH-1:0] lane_new;
    logic [DATA_WIDTH-1:0] lane_sum;

    assign wr_ready   = (state == WRITE);
    assign wr_fire_c  = wr_valid && (state == WRITE);
    assign store_c    = ((32'(x_cnt) % STRIDE) == 32'd0) && ((32'(y_cnt) % STRIDE) == 32'd0);
    assign row_end_c  = (32'(x_cnt) == CONV_SIZE - 1);
    assign end_pass_c = row_end_c && (32'(y_cnt) == CONV_SIZE - 1);
    assign wr_addr_c  = ADDR_W'((32'(y_cnt) / STRIDE) * OFM_SIZE + 32'(x_cnt) / STRIDE);
    assign mem_rd_c   = mem[wr_addr_c];
    assign rd_load_c  = (state == READ) && (!rd_valid || rd_ready) && (32'(rd_ptr) < DEPTH);
    assign rd_done_c  = (state == READ) && rd_valid && rd_ready && rd_last;

    // Per-channel store value: raw input on the first pass, else running sum.
    always_comb begin
        wr_data_c = '0;
        lane_old  = '0;
        lane_new  = '0;
        lane_sum  = '0;
        for (int c = 0; c < NUM_CHANNEL; c++) begin
            lane_old = mem_rd_c[c*DATA_WIDTH +: DATA_WIDTH];
            lane_new = d_in[c*DATA_WIDTH +: DATA_WIDTH];
            lane_sum = lane_old + lane_new;
`ifdef OFM_BUFFER_SAT_ACC_EN
            if ((lane_old[DATA_WIDTH-1] == lane_new[DATA_WIDTH-1]) &&
                (lane_sum[DATA_WIDTH-1] != lane_old[DATA_WIDTH-1])) begin
                lane_sum = lane_old[DATA_WIDTH-1] ? SAT_MIN : SAT_MAX;
            end
`endif
            wr_data_c[c*DATA_WIDTH +: DATA_WIDTH] = first_pass ? lane_new : lane_sum;
        end
    end

    // Storage: read-modify-write of one grid position per accepted beat.
    always_ff @(posedge clk) begin
        if (!rst && wr_fire_c && store_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Control FSM: raster counters in WRITE, registered output stage in READ.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WRITE;
            x_cnt      <= '0;
            y_cnt      <= '0;
            first_pass <= 1'b1;
            rd_ptr     <= '0;
            rd_valid   <= 1'b0;
            d_out      <= '0;
            rd_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                WRITE: begin
                    if (wr_valid) begin
                        if (end_pass_c) begin
                            x_cnt      <= '0;
                            y_cnt      <= '0;
                            frame_done <= 1'b1;
                            if (last_pass) begin
                                first_pass <= 1'b1;
                                state      <= READ;
                            end else begin
                                first_pass <= 1'b0;
                            end
                        end else if (row_end_c) begin
                            x_cnt <= '0;
                            y_cnt <= y_cnt + CNT_W'(1);
                        end else begin
                            x_cnt <= x_cnt + CNT_W'(1);
                        end
                    end
                end
                READ: begin
                    if (rd_done_c) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        rd_ptr   <= '0;
                        state    <= WRITE;
                    end else if (rd_load_c) begin
                        d_out    <= mem[rd_ptr[ADDR_W-1:0]];
                        rd_valid <= 1'b1;
                        rd_last  <= (32'(rd_ptr) == DEPTH - 1);
                        rd_ptr   <= rd_ptr + PTR_W'(1);
                    end
                end
                default: state <= WRITE;
            endcase
        end
    end

endmodule
